// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        NPC_OP_PC4  = 2'd0,
        NPC_OP_B    = 2'd1,
        NPC_OP_JAL  = 2'd2,
        NPC_OP_JALR = 2'd3
    } npc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Redirect target: JALR uses the ALU result, JAL/B use pc+imm; always word-aligned.
    function automatic logic [XLEN-1:0] npc_target(
        input logic [1:0]      op,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] imm,
        input logic [XLEN-1:0] alu
    );
        logic [XLEN-1:0] t;
        t = (op == NPC_OP_JALR) ? alu : XLEN'(pc + imm);
        return {t[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Two-entry in-order instruction buffer with flush; head entry is always slot0.
module inst_fifo
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               valid
);

    fetch_entry_t     slot0;
    fetch_entry_t     slot1;
    logic [CNT_W-1:0] cnt;
    logic             do_pop;
    logic             full;

    assign full   = (cnt == CNT_W'(BUF_DEPTH));
    assign do_pop = pop && (cnt != '0);

    // Flush wins over push/pop; simultaneous push+pop keeps the count and order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (cnt == '0) begin
                        slot0 <= push_data;
                        cnt   <= CNT_W'(1);
                    end else if (!full) begin
                        slot1 <= push_data;
                        cnt   <= CNT_W'(2);
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - CNT_W'(1);
                end
                2'b11: begin
                    if (cnt == CNT_W'(1)) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0;
    assign count = cnt;
    assign valid = (cnt != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-entry buffer, with EX redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc4,
    input  logic            ex_valid,
    input  logic [1:0]      npc_op,
    input  logic            br_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ext,
    input  logic [XLEN-1:0] alu_c
);

    localparam logic [XLEN-1:0] RESET_PC = {PC_RESET[XLEN-1:2], 2'b00};

    fetch_state_e     state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic             redirect;
    logic [XLEN-1:0]  target;
    logic             pop;
    logic             push;
    logic             granted;
    logic [CNT_W-1:0] count;
    logic             buf_valid;
    fetch_entry_t     head;
    fetch_entry_t     push_data;

    // Redirect decode from the executing instruction.
    always_comb begin
        redirect = 1'b0;
        if (ex_valid) begin
            case (npc_op)
                NPC_OP_JAL, NPC_OP_JALR: redirect = 1'b1;
                NPC_OP_B:                redirect = br_taken;
                default:                 redirect = 1'b0;
            endcase
        end
        target = npc_target(npc_op, ex_pc, ext, alu_c);
    end

    assign pop = buf_valid && inst_ready && !redirect;

    // Request only if the response is guaranteed a buffer slot; a same-cycle pop frees one.
    always_comb begin
        imem_req = 1'b0;
        if (rst_n && !redirect) begin
            case (state)
                IDLE:    imem_req = (count < CNT_W'(BUF_DEPTH)) || pop;
                WAIT:    imem_req = imem_rvalid &&
                                    ((count == '0) || ((count == CNT_W'(1)) && pop));
                default: imem_req = 1'b0;
            endcase
        end
    end

    assign granted   = imem_req && imem_gnt;
    assign push      = !redirect && (state == WAIT) && imem_rvalid;
    assign push_data = '{inst: imem_rdata, pc: req_pc};
    assign imem_addr = fetch_pc;

    // Fetch FSM and PC tracking; redirect overrides everything except reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target;
            case (state)
                WAIT:    state <= imem_rvalid ? IDLE : DROP;
                DROP:    state <= imem_rvalid ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            if (granted) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end
            case (state)
                IDLE: begin
                    if (granted) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) state <= granted ? WAIT : IDLE;
                end
                DROP: begin
                    if (imem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    inst_fifo u_inst_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .valid     (buf_valid)
    );

    assign inst_valid = buf_valid;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_pc4   = head.pc + PC_STEP;

endmodule
